dpc_ctrl: RTL and testbench
===========================

// Module: dpc_ctrl
// PURPOSE
//  Frame/line sequencer and configuration controller for the defective-pixel-correction datapath.
//  Tracks raw-stream coordinates from vsync/href and produces the Bayer phase of the 5x5 window centre.
//  Produces a border-valid flag for that centre and frame-synchronous (shadowed) enable/threshold.
//  Counts corrected pixels per frame and flags malformed frames.
//  Sits beside the DPC datapath: the datapath consumes ctr_fmt/ctr_valid/dpc_en/dpc_thr and returns defect_flag.
// PARAMETERS
//  BITS    8     raw pixel / threshold width
//  WIDTH   1936  active pixels per line
//  HEIGHT  960   active lines per frame
//  BAYER   2     0:RGGB 1:GRBG 2:GBRG 3:BGGR, phase of pixel (0,0)
//  CNT_W   20    defect counter width
// PORTS
//  pclk         in   1      pixel clock
//  rst_n        in   1      asynchronous reset, active-low
//  in_vsync     in   1      frame sync, active high; rising edge = frame start
//  in_href      in   1      line valid, one pixel per cycle while high
//  cfg_en       in   1      requested correction enable
//  cfg_thr      in   BITS   requested threshold
//  cfg_upd      in   1      1-cycle pulse: capture cfg_en/cfg_thr as pending
//  defect_flag  in   1      datapath: current output pixel was replaced
//  dpc_en       out  1      active enable (shadow)
//  dpc_thr      out  BITS   active threshold (shadow)
//  ctr_fmt      out  2      window-centre phase 0:R 1:Gr 2:Gb 3:B
//  ctr_valid    out  1      centre has a full 5x5 neighbourhood
//  frame_done   out  1      1-cycle pulse at end of frame
//  defect_cnt   out  CNT_W  defects in last completed frame
//  frame_err    out  1      sticky: line length != WIDTH or line count != HEIGHT
// BEHAVIOUR
//  Reset: all outputs 0; FSM in S_IDLE; pending cfg = {0,0}; x = y = 0.
//  FSM:
//   - S_IDLE: wait vsync rise -> S_VBLANK. Any href seen in S_IDLE is ignored (mid-frame join is not allowed).
//   - S_VBLANK: href rise -> S_LINE.
//   - S_LINE: x++ per cycle; href fall -> S_HBLANK; y++, x=0.
//   - S_HBLANK: href rise -> S_LINE; vsync rise -> S_VBLANK (frame end).
//  Frame start (vsync rise in S_IDLE or S_HBLANK/S_VBLANK):
//   - dpc_en/dpc_thr <= pending.
//   - defect accumulator cleared; y = 0.
//  Frame end (vsync rise after >=1 line):
//   - frame_done = 1 for one cycle.
//   - defect_cnt <= accumulator. If defect_flag is high in the same cycle, it counts toward the closing frame.
//  Config capture:
//   - cfg_upd captures into pending at any time; cfg is never applied mid-frame.
//   - cfg_upd coincident with frame start: the new value applies in that frame (bypass to shadow).
//  Coordinates: cx = x-2, cy = y-2 (window centre lags input by 2 lines, 2 pixels).
//  Outputs are registered: 1-cycle latency from in_href/pixel.
//   - ctr_valid = in_href & x>=4 & y>=4.
//   - ctr_fmt = {cy[0],cx[0]} ^ BAYER[1:0].
//  Accumulator: +1 per cycle with defect_flag=1; saturates at 2^CNT_W-1, no wrap.
//  frame_err:
//   - set if an href fall occurs with x != WIDTH, or x reaches WIDTH with href still high (overlong line);
//     an overlong line stops x at WIDTH.
//   - set if frame end occurs with y != HEIGHT.
//   - cleared only by rst_n.
//  Reset mid-frame: immediate return to S_IDLE. Pending cfg is lost. Output defect_cnt = 0.
// STRUCTURE
//  Package dpc_pkg: state enum (S_IDLE, S_VBLANK, S_LINE, S_HBLANK), Bayer phase codes, CTR_OFS=2.
//  Sub-module dpc_pos_cnt: x/y counters, length check, ctr_valid/ctr_fmt generation.
//  FSM, shadow config and statistics stay in dpc_ctrl.
// TESTING
//  1. Reset, then 8x6 frame (WIDTH=8, HEIGHT=6, BAYER=2):
//     -> ctr_valid first high at line 4, pixel 4; ctr_fmt there = 2; frame_err=0.
//  2. cfg_upd(en=1, thr=20) mid-frame:
//     -> dpc_en/dpc_thr stay 0/0 until next vsync rise, then 1/20.
//  3. defect_flag high for 5 cycles in frame N:
//     -> frame_done pulse at frame end with defect_cnt=5; next frame with none -> 0.
//  4. One line of 7 pixels in an 8-wide frame:
//     -> frame_err=1 at that href fall and stays 1 across following good frames.
//  5. CNT_W=3, 10 defects -> defect_cnt=7 (saturated).
//  6. rst_n asserted mid-line:
//     -> outputs 0 immediately; href ignored until vsync rise; next frame processed normally.

Source files
------------

// File: rtl/dpc_pkg.sv
// Shared definitions for the defective-pixel-correction frame/line controller.
// Sequencer states, Bayer phase codes and the window-centre offset.
package dpc_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_VBLANK = 2'd1;
    localparam logic [1:0] S_LINE   = 2'd2;
    localparam logic [1:0] S_HBLANK = 2'd3;

    typedef enum logic [1:0] {
        PH_R  = 2'd0,
        PH_GR = 2'd1,
        PH_GB = 2'd2,
        PH_B  = 2'd3
    } bayer_ph_e;

    // 5x5 window centre trails the incoming pixel by this many pixels and lines
    localparam int CTR_OFS = 2;

    function automatic bayer_ph_e ctr_phase(input logic cy0, input logic cx0,
                                            input logic [1:0] bayer);
        return bayer_ph_e'({cy0, cx0} ^ bayer);
    endfunction

endpackage

// File: rtl/dpc_pos_cnt.sv
// Raw-stream x/y position counters, line-length check and window-centre
// border-valid / Bayer-phase generation.
module dpc_pos_cnt
    import dpc_pkg::*;
#(
    parameter int WIDTH = 1936,
    parameter int BAYER = 2,
    parameter int YW    = 10
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          line_end,
    input  logic          pix,
    output logic [YW-1:0] y,
    output logic          len_err,
    output logic          ctr_valid,
    output logic [1:0]    ctr_fmt
);
    localparam int XW = $clog2(WIDTH + 1);
    localparam logic OFS_LSB = 1'(CTR_OFS % 2);

    logic [XW-1:0] x;
    logic          cx0, cy0;

    // Only the LSB of cx = x - CTR_OFS matters for the phase; subtraction keeps it as an XOR.
    assign cx0 = x[0] ^ OFS_LSB;
    assign cy0 = y[0] ^ OFS_LSB;

    assign len_err = (pix & (x == XW'(WIDTH))) | (line_end & (x != XW'(WIDTH)));

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (frame_start) begin
            x <= '0;
            y <= '0;
        end else if (line_end) begin
            x <= '0;
            y <= (y == '1) ? y : y + YW'(1);
        end else if (pix && (x != XW'(WIDTH))) begin
            x <= x + XW'(1);
        end
    end

    // stage p1: registered window-centre flags
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_valid <= 1'b0;
            ctr_fmt   <= 2'd0;
        end else begin
            ctr_valid <= pix & (x >= XW'(2 * CTR_OFS)) & (y >= YW'(2 * CTR_OFS));
            if (pix) begin
                ctr_fmt <= ctr_phase(cy0, cx0, 2'(BAYER));
            end
        end
    end

endmodule

// File: rtl/dpc_ctrl.sv
// Frame/line sequencer, frame-synchronous config shadowing and per-frame
// defect statistics for the defective-pixel-correction datapath.
module dpc_ctrl
    import dpc_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1936,
    parameter int HEIGHT = 960,
    parameter int BAYER  = 2,
    parameter int CNT_W  = 20
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             in_vsync,
    input  logic             in_href,
    input  logic             cfg_en,
    input  logic [BITS-1:0]  cfg_thr,
    input  logic             cfg_upd,
    input  logic             defect_flag,
    output logic             dpc_en,
    output logic [BITS-1:0]  dpc_thr,
    output logic [1:0]       ctr_fmt,
    output logic             ctr_valid,
    output logic             frame_done,
    output logic [CNT_W-1:0] defect_cnt,
    output logic             frame_err
);
    localparam int YW = $clog2(HEIGHT + 2);

    logic [1:0]       state, state_nx;
    logic             vsync_p1, href_p1;
    logic             vsync_rise, href_rise, href_fall;
    logic             frame_start, frame_end, line_end, pix, len_err;
    logic [YW-1:0]    y;
    logic             pend_en;
    logic [BITS-1:0]  pend_thr;
    logic [CNT_W-1:0] acc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != '1)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    assign vsync_rise  = in_vsync & ~vsync_p1;
    assign href_rise   = in_href & ~href_p1;
    assign href_fall   = ~in_href & href_p1;
    // vsync during an active line is ignored; a frame can only start/end in a blanking state
    assign frame_start = vsync_rise & (state != S_LINE);
    assign frame_end   = vsync_rise & (state == S_HBLANK);
    assign line_end    = href_fall & (state == S_LINE);
    assign pix = in_href & ((state == S_LINE) |
                 (((state == S_VBLANK) | (state == S_HBLANK)) & href_rise & ~vsync_rise));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (vsync_rise) state_nx = S_VBLANK;
            S_VBLANK: if (href_rise && !vsync_rise) state_nx = S_LINE;
            S_LINE:   if (href_fall) state_nx = S_HBLANK;
            S_HBLANK: begin
                if (vsync_rise) state_nx = S_VBLANK;
                else if (href_rise) state_nx = S_LINE;
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    // Edge detectors reset high so a level already asserted at reset release is not an edge.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            vsync_p1 <= 1'b1;
            href_p1  <= 1'b1;
        end else begin
            state    <= state_nx;
            vsync_p1 <= in_vsync;
            href_p1  <= in_href;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_en  <= 1'b0;
            pend_thr <= '0;
            dpc_en   <= 1'b0;
            dpc_thr  <= '0;
        end else begin
            if (cfg_upd) begin
                pend_en  <= cfg_en;
                pend_thr <= cfg_thr;
            end
            if (frame_start) begin
                dpc_en  <= cfg_upd ? cfg_en  : pend_en;
                dpc_thr <= cfg_upd ? cfg_thr : pend_thr;
            end
        end
    end

    // stage p1: frame statistics; a defect in the closing vsync cycle belongs to the old frame
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            defect_cnt <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            acc        <= frame_start ? '0 : sat_inc(acc, defect_flag);
            frame_done <= frame_end;
            if (frame_end) begin
                defect_cnt <= sat_inc(acc, defect_flag);
            end
            frame_err  <= frame_err | len_err | (frame_end & (y != YW'(HEIGHT)));
        end
    end

    dpc_pos_cnt #(
        .WIDTH (WIDTH),
        .BAYER (BAYER),
        .YW    (YW)
    ) u_pos_cnt (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .line_end    (line_end),
        .pix         (pix),
        .y           (y),
        .len_err     (len_err),
        .ctr_valid   (ctr_valid),
        .ctr_fmt     (ctr_fmt)
    );

endmodule

// File: tb/tb_dpc_ctrl.sv
// Scoreboard bench for dpc_ctrl: frame-level reference model feeds expectation
// queues; a negedge monitor pops and compares whenever the DUT presents output.
module tb_dpc_ctrl;
    localparam int BITS    = 8;
    localparam int WIDTH   = 8;
    localparam int HEIGHT  = 6;
    localparam int BAYER   = 2;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             pclk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_vsync = 1'b0, in_href = 1'b0;
    logic             cfg_en = 1'b0, cfg_upd = 1'b0, defect_flag = 1'b0;
    logic [BITS-1:0]  cfg_thr = '0;
    logic             dpc_en, ctr_valid, frame_done, frame_err;
    logic [BITS-1:0]  dpc_thr;
    logic [1:0]       ctr_fmt;
    logic [CNT_W-1:0] defect_cnt;

    dpc_ctrl #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BAYER(BAYER), .CNT_W(CNT_W)) dut (
        .pclk(pclk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href),
        .cfg_en(cfg_en), .cfg_thr(cfg_thr), .cfg_upd(cfg_upd), .defect_flag(defect_flag),
        .dpc_en(dpc_en), .dpc_thr(dpc_thr), .ctr_fmt(ctr_fmt), .ctr_valid(ctr_valid),
        .frame_done(frame_done), .defect_cnt(defect_cnt), .frame_err(frame_err)
    );

    always #5 pclk = ~pclk;

    typedef struct { int fmt; int en; int thr; } pix_t;
    typedef struct { int cnt; int err; } done_t;
    pix_t  pix_q[$];
    done_t done_q[$];

    int n_chk = 0, n_fail = 0;

    // reference model state
    int pend_en = 0, pend_thr = 0, sh_en = 0, sh_thr = 0;
    int line_no = 0, raw_cnt = 0, m_err = 0, in_frame = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        pix_t  pe;
        done_t de;
        if (rst_n) begin
            if (ctr_valid) begin
                if (pix_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL ctr_valid: got 1 expected 0 (no centre pending) at %0t", $time);
                end else begin
                    pe = pix_q.pop_front();
                    check("ctr_fmt", int'(ctr_fmt), pe.fmt);
                    check("dpc_en", int'(dpc_en), pe.en);
                    check("dpc_thr", int'(dpc_thr), pe.thr);
                end
            end
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL frame_done: got 1 expected 0 (no frame end pending) at %0t", $time);
                end else begin
                    de = done_q.pop_front();
                    check("defect_cnt", int'(defect_cnt), de.cnt);
                    check("frame_err", int'(frame_err), de.err);
                end
            end
        end
    end

    task automatic cyc(input logic vs, input logic hr, input logic df, input logic upd);
        in_vsync    = vs;
        in_href     = hr;
        defect_flag = df;
        cfg_upd     = upd;
        @(posedge pclk);
        #1;
    endtask

    function automatic int exp_fmt(input int px, input int ln);
        int xc, cx, cy;
        xc = (px < WIDTH) ? px : WIDTH;
        cx = xc - 2;
        cy = ln - 2;
        return (((cy & 1) << 1) | (cx & 1)) ^ BAYER;
    endfunction

    // Frame boundary: closes the previous frame (if it had lines) and opens a new one.
    task automatic vsync_pulse(input bit upd, input bit en, input int thr, input bit df);
        if (in_frame != 0 && line_no > 0) begin
            raw_cnt += df;
            if (line_no != HEIGHT) m_err = 1;
            done_q.push_back('{cnt: (raw_cnt > CNT_MAX) ? CNT_MAX : raw_cnt, err: m_err});
        end
        if (upd) begin
            pend_en  = en;
            pend_thr = thr;
        end
        sh_en    = pend_en;
        sh_thr   = pend_thr;
        raw_cnt  = 0;
        line_no  = 0;
        in_frame = 1;
        cfg_en   = en;
        cfg_thr  = BITS'(thr);
        cyc(1, 0, df, upd);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    task automatic send_line(input int len, input bit rnd);
        bit df;
        for (int p = 0; p < len; p++) begin
            df = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
            raw_cnt += df;
            if (p >= 4 && line_no >= 4)
                pix_q.push_back('{fmt: exp_fmt(p, line_no), en: sh_en, thr: sh_thr});
            cyc(0, 1, df, 0);
        end
        if (len != WIDTH) m_err = 1;
        for (int h = 0; h < 3; h++) begin
            df = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
            raw_cnt += df;
            cyc(0, 0, df, 0);
        end
        line_no++;
    endtask

    task automatic cfg_write(input bit en, input int thr);
        cfg_en   = en;
        cfg_thr  = BITS'(thr);
        pend_en  = en;
        pend_thr = thr;
        cyc(0, 0, 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " dpc_en"}, int'(dpc_en), 0);
        check({tag, " dpc_thr"}, int'(dpc_thr), 0);
        check({tag, " ctr_fmt"}, int'(ctr_fmt), 0);
        check({tag, " ctr_valid"}, int'(ctr_valid), 0);
        check({tag, " frame_done"}, int'(frame_done), 0);
        check({tag, " defect_cnt"}, int'(defect_cnt), 0);
        check({tag, " frame_err"}, int'(frame_err), 0);
    endtask

    initial begin
        bit up, en, mid;
        int thr;

        repeat (3) cyc(0, 0, 0, 0);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) cyc(0, 0, 0, 0);

        // Clean frame, config written mid-frame must not apply yet
        vsync_pulse(0, 0, 0, 0);
        repeat (3) send_line(WIDTH, 0);
        cfg_write(1, 20);
        repeat (3) send_line(WIDTH, 0);

        // Config takes effect at frame start; exactly 5 defects
        vsync_pulse(0, 0, 0, 0);
        repeat (2) send_line(WIDTH, 0);
        for (int i = 0; i < 5; i++) begin
            raw_cnt++;
            cyc(0, 0, 1, 0);
        end
        repeat (4) send_line(WIDTH, 0);

        // Frame with no defects
        vsync_pulse(0, 0, 0, 0);
        repeat (HEIGHT) send_line(WIDTH, 0);

        // 10 defects plus one on the closing vsync: saturates
        vsync_pulse(0, 0, 0, 0);
        send_line(WIDTH, 0);
        for (int i = 0; i < 10; i++) begin
            raw_cnt++;
            cyc(0, 0, 1, 0);
        end
        repeat (5) send_line(WIDTH, 0);
        vsync_pulse(0, 0, 0, 1);

        // Randomized frames: random defects, config on or off the frame boundary
        for (int f = 0; f < 4; f++) begin
            repeat (HEIGHT) send_line(WIDTH, 1);
            up  = 1'($urandom_range(0, 1));
            en  = 1'($urandom_range(0, 1));
            thr = int'($urandom_range(0, 255));
            vsync_pulse(up, en, thr, 1'($urandom_range(0, 1)));
            mid = 1'($urandom_range(0, 1));
            if (mid) cfg_write(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
        end

        // Short line (7 of 8) sets sticky error; following frames stay flagged
        for (int l = 0; l < HEIGHT; l++) send_line((l == 2) ? WIDTH - 1 : WIDTH, 1);
        vsync_pulse(0, 0, 0, 0);
        repeat (HEIGHT) send_line(WIDTH, 0);
        vsync_pulse(0, 0, 0, 0);
        // Overlong line on a valid-centre row, then a frame one line short
        for (int l = 0; l < HEIGHT; l++) send_line((l == 5) ? WIDTH + 2 : WIDTH, 0);
        vsync_pulse(0, 0, 0, 0);
        repeat (HEIGHT - 1) send_line(WIDTH, 0);
        vsync_pulse(0, 0, 0, 0);

        // Reset in the middle of a line with valid centres in flight
        cfg_write(1, 55);
        repeat (4) send_line(WIDTH, 0);
        for (int p = 0; p < 6; p++) begin
            if (p >= 4)
                pix_q.push_back('{fmt: exp_fmt(p, line_no), en: sh_en, thr: sh_thr});
            cyc(0, 1, 0, 0);
        end
        check("pre-reset ctr_valid", int'(ctr_valid), 1);
        check("pre-reset frame_err", int'(frame_err), m_err);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        pix_q.delete();
        done_q.delete();
        pend_en = 0; pend_thr = 0; sh_en = 0; sh_thr = 0;
        line_no = 0; raw_cnt = 0; m_err = 0; in_frame = 0;
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
        // href activity while idle must produce nothing
        repeat (3) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (WIDTH) cyc(0, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0);
        check("idle frame_err", int'(frame_err), 0);

        vsync_pulse(0, 0, 0, 0);
        repeat (HEIGHT) send_line(WIDTH, 1);
        vsync_pulse(0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);

        check("centres outstanding", pix_q.size(), 0);
        check("frame ends outstanding", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
